// File: rtl/smi_self_link_flit_serializer.sv
// smi_self_link_flit_serializer
// Width-reducing SELF link stage: takes one wide word from the link buffer and
// emits it as FlitWidth-bit flits, least significant flit first, with a
// last-flit marker on the final flit.
// Build option: SMI_SELF_SERIALIZER_PARTIAL_EN honours dataInLen (partial words);
// when it is undefined every word emits exactly FlitRatio flits.

module smi_self_link_flit_serializer #(
  parameter int unsigned FlitWidth      = 8,
  parameter int unsigned FlitRatio      = 4,
  parameter int unsigned RatioIndexSize = 2
) (
  input  logic                           clk,
  input  logic                           srst,
  input  logic                           dataInValid,
  input  logic [FlitWidth*FlitRatio-1:0] dataIn,
  input  logic [RatioIndexSize-1:0]      dataInLen,
  output logic                           dataInStop,
  output logic                           dataOutValid,
  output logic [FlitWidth-1:0]           dataOut,
  output logic                           dataOutLast,
  input  logic                           dataOutStop
);

  localparam logic [RatioIndexSize-1:0] MaxIndex = RatioIndexSize'(FlitRatio - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                                state_q, state_d;
  logic [RatioIndexSize-1:0]             index_q, index_d;
  logic [RatioIndexSize-1:0]             len_q, len_d;
  logic [FlitRatio-1:0][FlitWidth-1:0]   word_q, word_d;
  logic                                  out_valid_d;
  logic [FlitWidth-1:0]                  out_data_d;
  logic                                  out_last_d;
  logic [RatioIndexSize-1:0]             len_in;
  logic                                  out_advance;
  logic                                  at_last;

  // Effective final-flit index for an incoming word
`ifdef SMI_SELF_SERIALIZER_PARTIAL_EN
  if (FlitRatio == (1 << RatioIndexSize)) begin : g_len_direct
    assign len_in = dataInLen;
  end else begin : g_len_clamp
    assign len_in = (dataInLen > MaxIndex) ? MaxIndex : dataInLen;
  end
`else
  logic unused_len;
  assign unused_len = ^dataInLen;
  assign len_in     = MaxIndex;
`endif

  // Output register may load whenever it is empty or its flit is being taken
  assign out_advance = ~(dataOutValid & dataOutStop);
  assign at_last     = (index_q == len_q);

  // Upstream is held off while a word remains, except on the edge its last flit leaves
  assign dataInStop  = (state_q == SHIFT) & ~(out_advance & at_last);

  // Next-state and datapath selection
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    len_d       = len_q;
    word_d      = word_q;
    out_valid_d = dataOutValid;
    out_data_d  = dataOut;
    out_last_d  = dataOutLast;
    case (state_q)
      EMPTY: begin
        if (out_advance) begin
          out_valid_d = 1'b0;
        end
        if (dataInValid) begin
          word_d  = dataIn;
          len_d   = len_in;
          index_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_advance) begin
          out_valid_d = 1'b1;
          out_data_d  = word_q[index_q];
          out_last_d  = at_last;
          if (!at_last) begin
            index_d = RatioIndexSize'(index_q + 1'b1);
          end else begin
            index_d = '0;
            if (dataInValid) begin
              word_d = dataIn;
              len_d  = len_in;
            end else begin
              state_d = EMPTY;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control state and output valid, cleared by reset
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= EMPTY;
      index_q      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      dataOutValid <= out_valid_d;
    end
  end

  // Datapath registers, meaningful only while qualified by the control state
  always_ff @(posedge clk) begin
    word_q      <= word_d;
    len_q       <= len_d;
    dataOut     <= out_data_d;
    dataOutLast <= out_last_d;
  end

endmodule

// File: tb/tb_smi_self_link_flit_serializer.sv
// Bench for smi_self_link_flit_serializer: directed steps plus random traffic,
// checked every cycle against a queue-based reference model of the stage.

module tb_smi_self_link_flit_serializer;

  localparam int unsigned FW = 8;
  localparam int unsigned FR = 4;
  localparam int unsigned RI = 2;

  logic          clk;
  logic          srst;
  logic          dvalid;
  logic [31:0]   din;
  logic [1:0]    dlen;
  logic          in_stop;
  logic          ov;
  logic [7:0]    od;
  logic          ol;
  logic          dstop;

  smi_self_link_flit_serializer #(
    .FlitWidth(FW), .FlitRatio(FR), .RatioIndexSize(RI)
  ) dut (
    .clk(clk), .srst(srst),
    .dataInValid(dvalid), .dataIn(din), .dataInLen(dlen), .dataInStop(in_stop),
    .dataOutValid(ov), .dataOut(od), .dataOutLast(ol), .dataOutStop(dstop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       l;
  } xfer_t;

  xfer_t      log_q[$];
  logic [8:0] cur[$];     // {last, data} flits of the held word not yet presented
  logic       mv;
  logic [7:0] md;
  logic       ml;
  int         total, bad, cyc, acc_cyc, pushed, stall_pct;
  logic       armed, accepted;
  logic       s_valid, s_instop, s_last;
  logic [7:0] s_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_len(input logic [1:0] l);
`ifdef SMI_SELF_SERIALIZER_PARTIAL_EN
    return int'(l);
`else
    logic unused_l;
    unused_l = ^l;
    return int'(FR) - 1;
`endif
  endfunction

  // One clock: sample at negedge, compare with model, advance model over the edge
  task automatic tick();
    logic adv, exp_stop, in_x;
    int   n;
    @(negedge clk);
    s_valid  = ov;
    s_instop = in_stop;
    s_data   = od;
    s_last   = ol;
    adv      = !(mv && dstop);
    exp_stop = (cur.size() > 0) && !(adv && cur.size() == 1);
    if (armed) begin
      chk("out_valid", 32'(ov), 32'(mv));
      chk("in_stop", 32'(in_stop), 32'(exp_stop));
      if (mv) begin
        chk("out_data", 32'(od), 32'(md));
        chk("out_last", 32'(ol), 32'(ml));
      end
    end
    in_x     = dvalid && !exp_stop && !srst;
    accepted = in_x;
    if (mv && !dstop) log_q.push_back('{cyc, md, ml});
    if (srst) begin
      cur.delete();
      mv    = 1'b0;
      armed = 1'b1;
    end else begin
      if (adv) begin
        if (cur.size() > 0) begin
          {ml, md} = cur.pop_front();
          mv = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
      if (in_x) begin
        n = eff_len(dlen);
        for (int k = 0; k <= n; k++) begin
          cur.push_back({(k == n), din[k*8 +: 8]});
          pushed++;
        end
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall_pct > 0) dstop = ($urandom_range(99, 0) < stall_pct);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] l);
    din      = w;
    dlen     = l;
    dvalid   = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) tick();
    chk("accept", 32'(accepted), 32'd1);
    dvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a, a2, n;
    logic [7:0] ex[$];

    total = 0; bad = 0; cyc = 0; acc_cyc = 0; pushed = 0; stall_pct = 0;
    armed = 1'b0; accepted = 1'b0; mv = 1'b0; md = '0; ml = 1'b0;
    srst = 1'b1; dvalid = 1'b1; din = 32'hA4A3A2A1; dlen = 2'd3; dstop = 1'b0;

    // Reset held 3 cycles with a word offered
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_in_stop", 32'(s_instop), 32'd0);
    end
    srst = 1'b0;
    tick();
    chk("first_accept", 32'(accepted), 32'd1);
    dvalid = 1'b0;
    idle(8);

    // Single word, no stalls
    log_q.delete();
    send(32'h44332211, 2'd3);
    a = acc_cyc;
    idle(8);
    chk("single_n", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("single_data", 32'(log_q[k].d), 32'((k + 1) * 17));
        chk("single_last", 32'(log_q[k].l), 32'(k == 3));
        chk("single_cyc", 32'(log_q[k].cyc), 32'(a + 2 + k));
      end
    end

    // Back-to-back streaming
    log_q.delete();
    send(32'h04030201, 2'd3);
    send(32'h08070605, 2'd3);
    a2 = acc_cyc;
    idle(10);
    chk("b2b_n", 32'(log_q.size()), 32'd8);
    if (log_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("b2b_data", 32'(log_q[k].d), 32'(k + 1));
        chk("b2b_last", 32'(log_q[k].l), 32'(k == 3 || k == 7));
        chk("b2b_cyc", 32'(log_q[k].cyc), 32'(log_q[0].cyc + k));
      end
      chk("b2b_accept_edge", 32'(log_q[3].cyc), 32'(a2 + 1));
    end

    // Stall mid-word while flit 22 is presented
    log_q.delete();
    send(32'h44332211, 2'd3);
    tick();
    tick();
    dstop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_data", 32'(s_data), 32'h22);
      chk("stall_in_stop", 32'(s_instop), 32'd1);
    end
    dstop = 1'b0;
    idle(6);
    chk("stall_n", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("stall_seq", 32'(log_q[k].d), 32'((k + 1) * 17));
    end

    // Partial word followed immediately by a full word
    log_q.delete();
    send(32'hDDCCBBAA, 2'd1);
    send(32'h55667788, 2'd3);
    idle(10);
    n = eff_len(2'd1) + 1;
    ex.delete();
    for (int k = 0; k < n; k++) ex.push_back(8'hAA + 8'(k * 17));
    ex.push_back(8'h88); ex.push_back(8'h77); ex.push_back(8'h66); ex.push_back(8'h55);
    chk("part_n", 32'(log_q.size()), 32'(n + 4));
    if (log_q.size() == n + 4) begin
      for (int k = 0; k < n + 4; k++) begin
        chk("part_data", 32'(log_q[k].d), 32'(ex[k]));
        chk("part_last", 32'(log_q[k].l), 32'(k == n - 1 || k == n + 3));
      end
      chk("part_next_flit0", 32'(log_q[n].cyc), 32'(log_q[n - 1].cyc + 1));
    end

    // Reset in the middle of a word
    log_q.delete();
    send(32'h44332211, 2'd3);
    tick();
    tick();
    srst = 1'b1;
    tick();
    chk("rstmid_pre", 32'(s_data), 32'h22);
    srst = 1'b0;
    tick();
    chk("rstmid_valid", 32'(s_valid), 32'd0);
    log_q.delete();
    send(32'h0D0C0B0A, 2'd3);
    idle(8);
    chk("rstmid_n", 32'(log_q.size()), 32'd4);
    if (log_q.size() > 0) chk("rstmid_flit0", 32'(log_q[0].d), 32'h0A);

    // Random traffic with random downstream stalls and upstream gaps
    log_q.delete();
    pushed    = 0;
    stall_pct = 30;
    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(3, 0) == 0) tick();
      send($urandom, 2'($urandom_range(3, 0)));
    end
    stall_pct = 0;
    dstop     = 1'b0;
    idle(12);
    chk("rand_count", 32'(log_q.size()), 32'(pushed));
    chk("rand_drain", 32'(cur.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
